// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared integer register file constants and index type
//
// Purpose : default data width, register count, register-index typedef and
//           the hardwired-zero register index used by regfile_mp and its
//           scoreboard.
// Ports   : none (package)
package rv_pkg;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);

   typedef logic [AW-1:0] reg_idx_t;

   localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy scoreboard for in-flight producers
//
// Purpose : one busy bit per architectural register. Set by alloc (issue of a
//           long-latency op), cleared by the retiring write, all cleared by
//           flush. Register 0 is never busy.
// Ports   : i_clk        clock
//           i_rst_n      async active-low reset
//           i_wr_en      per-port write enables (retiring producers)
//           i_wr_addr    packed write indices, port j at [j*AW +: AW]
//           i_alloc_en   mark i_alloc_addr busy
//           i_alloc_addr register to mark busy
//           i_flush      clear every busy bit
//           o_busy_vec   registered busy vector, bit k = register k
module regfile_scoreboard
   import rv_pkg::*;
#(
   parameter int NREG   = rv_pkg::NREG,
   parameter int AW     = $clog2(NREG),
   parameter int NUM_WR = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_WR-1:0]    i_wr_en,
   input  logic [NUM_WR*AW-1:0] i_wr_addr,
   input  logic                 i_alloc_en,
   input  logic [AW-1:0]        i_alloc_addr,
   input  logic                 i_flush,
   output logic [NREG-1:0]      o_busy_vec
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_next;

   // Applied lowest priority first so later statements override: retiring
   // writes clear, then a new alloc re-sets (it supersedes a same-cycle
   // retire), then flush wipes everything including that alloc.
   always_comb begin
      w_busy_next = r_busy;
      for (int j = 0; j < NUM_WR; j++) begin
         if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
            w_busy_next[i_wr_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (i_alloc_en && (i_alloc_addr != AW'(ZERO_REG))) begin
         w_busy_next[i_alloc_addr] = 1'b1;
      end
      if (i_flush) begin
         w_busy_next = '0;
      end
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_next;
      end
   end

   assign o_busy_vec = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with bypass and busy scoreboard
//
// Purpose : NUM_RD combinational read ports, NUM_WR write ports (higher port
//           wins on collision), optional same-cycle write-to-read bypass,
//           hardwired-zero register 0 and a per-register busy scoreboard.
// Ports   : i_clk        clock
//           i_rst_n      async active-low reset (clears storage and busy)
//           i_rd_addr    packed read indices, port i at [i*AW +: AW]
//           o_rd_data    packed read data, port i at [i*XLEN +: XLEN]
//           o_rd_busy    read register has an outstanding producer
//           i_wr_en      write enables
//           i_wr_addr    packed write indices
//           i_wr_data    packed write data
//           i_alloc_en   mark i_alloc_addr busy
//           i_alloc_addr register to mark busy
//           i_flush      clear all busy bits
//           o_busy_vec   full scoreboard
module regfile_mp
   import rv_pkg::*;
#(
   parameter int XLEN   = rv_pkg::XLEN,
   parameter int NREG   = rv_pkg::NREG,
   parameter int AW     = $clog2(NREG),
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 1,
   parameter int BYPASS = 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_RD*AW-1:0]   i_rd_addr,
   output logic [NUM_RD*XLEN-1:0] o_rd_data,
   output logic [NUM_RD-1:0]      o_rd_busy,
   input  logic [NUM_WR-1:0]      i_wr_en,
   input  logic [NUM_WR*AW-1:0]   i_wr_addr,
   input  logic [NUM_WR*XLEN-1:0] i_wr_data,
   input  logic                   i_alloc_en,
   input  logic [AW-1:0]          i_alloc_addr,
   input  logic                   i_flush,
   output logic [NREG-1:0]        o_busy_vec
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] w_busy_vec;

   // Storage. Ports are visited in ascending order so the last non-blocking
   // assignment, from the highest matching port, wins a collision.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int k = 0; k < NREG; k++) begin
            r_regs[k] <= '0;
         end
      end else begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
               r_regs[i_wr_addr[j*AW +: AW]] <= i_wr_data[j*XLEN +: XLEN];
            end
         end
      end
   end

   regfile_scoreboard #(
      .NREG   (NREG),
      .AW     (AW),
      .NUM_WR (NUM_WR)
   ) u_scoreboard (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_wr_en      (i_wr_en),
      .i_wr_addr    (i_wr_addr),
      .i_alloc_en   (i_alloc_en),
      .i_alloc_addr (i_alloc_addr),
      .i_flush      (i_flush),
      .o_busy_vec   (w_busy_vec)
   );

   assign o_busy_vec = w_busy_vec;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_data;
      logic            w_hit;

      assign w_addr = i_rd_addr[i*AW +: AW];

      // w_hit marks a same-cycle write to this index being forwarded; a
      // forwarded result also masks the busy bit so its consumer need not stall.
      always_comb begin
         w_data = r_regs[w_addr];
         w_hit  = 1'b0;
         if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WR; j++) begin
               if (i_wr_en[j] && (i_wr_addr[j*AW +: AW] == w_addr)) begin
                  w_data = i_wr_data[j*XLEN +: XLEN];
                  w_hit  = 1'b1;
               end
            end
         end
         if (w_addr == AW'(ZERO_REG)) begin
            w_data = '0;
            w_hit  = 1'b0;
         end
      end

      assign o_rd_data[i*XLEN +: XLEN] = w_data;
      assign o_rd_busy[i] = w_busy_vec[w_addr] & ~w_hit & (w_addr != AW'(ZERO_REG));
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass builds)
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // DUT A: two write ports, bypass on
   logic [2*AW-1:0]   a_rd_addr;
   logic [2*XLEN-1:0] a_rd_data;
   logic [1:0]        a_rd_busy;
   logic [1:0]        a_wr_en;
   logic [2*AW-1:0]   a_wr_addr;
   logic [2*XLEN-1:0] a_wr_data;
   logic              a_alloc_en;
   logic [AW-1:0]     a_alloc_addr;
   logic              a_flush;
   logic [NREG-1:0]   a_busy_vec;

   // DUT B: one write port, bypass off
   logic [2*AW-1:0]   b_rd_addr;
   logic [2*XLEN-1:0] b_rd_data;
   logic [1:0]        b_rd_busy;
   logic [0:0]        b_wr_en;
   logic [AW-1:0]     b_wr_addr;
   logic [XLEN-1:0]   b_wr_data;
   logic              b_alloc_en;
   logic [AW-1:0]     b_alloc_addr;
   logic              b_flush;
   logic [NREG-1:0]   b_busy_vec;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rd_addr(a_rd_addr), .o_rd_data(a_rd_data), .o_rd_busy(a_rd_busy),
      .i_wr_en(a_wr_en), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data),
      .i_alloc_en(a_alloc_en), .i_alloc_addr(a_alloc_addr), .i_flush(a_flush),
      .o_busy_vec(a_busy_vec)
   );

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_rd_addr(b_rd_addr), .o_rd_data(b_rd_data), .o_rd_busy(b_rd_busy),
      .i_wr_en(b_wr_en), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data),
      .i_alloc_en(b_alloc_en), .i_alloc_addr(b_alloc_addr), .i_flush(b_flush),
      .o_busy_vec(b_busy_vec)
   );

   // Reference model: architectural state as plain arrays
   logic [XLEN-1:0] ma_regs [NREG];
   logic [XLEN-1:0] mb_regs [NREG];
   logic [NREG-1:0] ma_busy;
   logic [NREG-1:0] mb_busy;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clear_models();
      for (int k = 0; k < NREG; k++) begin
         ma_regs[k] = '0;
         mb_regs[k] = '0;
      end
      ma_busy = '0;
      mb_busy = '0;
   endtask

   // A register written this cycle by DUT A (any port), and the forwarded value
   function automatic logic a_written(input int k);
      logic hit;
      hit = 1'b0;
      for (int j = 0; j < 2; j++)
         if (a_wr_en[j] && a_wr_addr[j*AW +: AW] == AW'(k)) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [XLEN-1:0] a_fwd(input int k);
      logic [XLEN-1:0] v;
      v = ma_regs[k];
      for (int j = 0; j < 2; j++)
         if (a_wr_en[j] && a_wr_addr[j*AW +: AW] == AW'(k)) v = a_wr_data[j*XLEN +: XLEN];
      return v;
   endfunction

   task automatic check_models();
      int ra, rb;
      for (int p = 0; p < 2; p++) begin
         ra = int'(a_rd_addr[p*AW +: AW]);
         rb = int'(b_rd_addr[p*AW +: AW]);
         chk($sformatf("A rd_data[%0d] x%0d", p, ra), 64'(a_rd_data[p*XLEN +: XLEN]),
             (ra == 0) ? 64'd0 : 64'(a_fwd(ra)));
         chk($sformatf("A rd_busy[%0d] x%0d", p, ra), 64'(a_rd_busy[p]),
             64'(ra != 0 && ma_busy[ra] && !a_written(ra)));
         chk($sformatf("B rd_data[%0d] x%0d", p, rb), 64'(b_rd_data[p*XLEN +: XLEN]),
             (rb == 0) ? 64'd0 : 64'(mb_regs[rb]));
         chk($sformatf("B rd_busy[%0d] x%0d", p, rb), 64'(b_rd_busy[p]),
             64'(rb != 0 && mb_busy[rb]));
      end
      chk("A busy_vec", 64'(a_busy_vec), 64'(ma_busy));
      chk("B busy_vec", 64'(b_busy_vec), 64'(mb_busy));
   endtask

   // Clock-edge state update computed from the rules on the pre-edge inputs
   task automatic update_models();
      logic [NREG-1:0] na, nb;
      logic bw;
      for (int k = 0; k < NREG; k++) begin
         na[k] = (k != 0) && !a_flush &&
                 ((a_alloc_en && int'(a_alloc_addr) == k) || (ma_busy[k] && !a_written(k)));
         bw    = b_wr_en[0] && int'(b_wr_addr) == k;
         nb[k] = (k != 0) && !b_flush &&
                 ((b_alloc_en && int'(b_alloc_addr) == k) || (mb_busy[k] && !bw));
      end
      for (int j = 0; j < 2; j++)
         if (a_wr_en[j] && a_wr_addr[j*AW +: AW] != 0)
            ma_regs[a_wr_addr[j*AW +: AW]] = a_wr_data[j*XLEN +: XLEN];
      if (b_wr_en[0] && b_wr_addr != 0) mb_regs[b_wr_addr] = b_wr_data;
      ma_busy = na;
      mb_busy = nb;
   endtask

   task automatic tick();
      @(posedge clk);
      update_models();
      #1;
   endtask

   task automatic step();
      @(negedge clk);
      check_models();
      tick();
   endtask

   task automatic idle_a();
      a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
      a_alloc_en = 1'b0; a_alloc_addr = '0; a_flush = 1'b0;
   endtask

   task automatic idle_b();
      b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
      b_alloc_en = 1'b0; b_alloc_addr = '0; b_flush = 1'b0;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG-1));
      return AW'($urandom_range(0, 7));
   endfunction

   typedef struct {
      logic [1:0]      we;
      logic [AW-1:0]   wa0;
      logic [XLEN-1:0] wd0;
      logic [AW-1:0]   wa1;
      logic [XLEN-1:0] wd1;
      logic            al;
      logic [AW-1:0]   aa;
      logic            fl;
      logic [AW-1:0]   r0;
      logic [AW-1:0]   r1;
      logic [XLEN-1:0] e0;
      logic [XLEN-1:0] e1;
      logic [1:0]      eb;
      logic [NREG-1:0] ebv;
   } vec_t;

   vec_t tbl [17];

   initial begin
      //          we     wa0 wd0           wa1 wd1  al  aa  fl  r0  r1  e0            e1            eb     ebv
      tbl[0]  = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 5,  0,  32'h0,        32'h0,        2'b00, 32'h0};
      tbl[1]  = '{2'b01, 0,  32'h1234,     0,  32'h0, 1, 0,  0, 0,  0,  32'h0,        32'h0,        2'b00, 32'h0};
      tbl[2]  = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 0,  0,  32'h0,        32'h0,        2'b00, 32'h0};
      tbl[3]  = '{2'b01, 3,  32'hA5A5A5A5, 0,  32'h0, 0, 0,  0, 3,  3,  32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 32'h0};
      tbl[4]  = '{2'b11, 7,  32'h1,        7,  32'h2, 0, 0,  0, 7,  3,  32'h2,        32'hA5A5A5A5, 2'b00, 32'h0};
      tbl[5]  = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 7,  7,  32'h2,        32'h2,        2'b00, 32'h0};
      tbl[6]  = '{2'b00, 0,  32'h0,        0,  32'h0, 1, 9,  0, 9,  0,  32'h0,        32'h0,        2'b00, 32'h0};
      tbl[7]  = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 9,  9,  32'h0,        32'h0,        2'b11, 32'h200};
      tbl[8]  = '{2'b01, 9,  32'h55,       0,  32'h0, 0, 0,  0, 9,  9,  32'h55,       32'h55,       2'b00, 32'h200};
      tbl[9]  = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 9,  9,  32'h55,       32'h55,       2'b00, 32'h0};
      tbl[10] = '{2'b01, 9,  32'h66,       0,  32'h0, 1, 9,  0, 9,  3,  32'h66,       32'hA5A5A5A5, 2'b00, 32'h0};
      tbl[11] = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 9,  9,  32'h66,       32'h66,       2'b11, 32'h200};
      tbl[12] = '{2'b00, 0,  32'h0,        0,  32'h0, 1, 4,  0, 4,  0,  32'h0,        32'h0,        2'b00, 32'h200};
      tbl[13] = '{2'b00, 0,  32'h0,        0,  32'h0, 1, 6,  0, 4,  6,  32'h0,        32'h0,        2'b01, 32'h210};
      tbl[14] = '{2'b00, 0,  32'h0,        0,  32'h0, 1, 8,  0, 6,  4,  32'h0,        32'h0,        2'b11, 32'h250};
      tbl[15] = '{2'b00, 0,  32'h0,        0,  32'h0, 1, 10, 1, 8,  10, 32'h0,        32'h0,        2'b01, 32'h350};
      tbl[16] = '{2'b00, 0,  32'h0,        0,  32'h0, 0, 0,  0, 10, 9,  32'h0,        32'h66,       2'b00, 32'h0};

      rst_n = 1'b0;
      idle_a(); idle_b();
      a_rd_addr = '0; b_rd_addr = '0;
      clear_models();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed table on the bypass / dual-write build
      for (int i = 0; i < 17; i++) begin
         a_wr_en      = tbl[i].we;
         a_wr_addr    = {tbl[i].wa1, tbl[i].wa0};
         a_wr_data    = {tbl[i].wd1, tbl[i].wd0};
         a_alloc_en   = tbl[i].al;
         a_alloc_addr = tbl[i].aa;
         a_flush      = tbl[i].fl;
         a_rd_addr    = {tbl[i].r1, tbl[i].r0};
         @(negedge clk);
         chk($sformatf("tbl%0d rd_data0", i), 64'(a_rd_data[XLEN-1:0]), 64'(tbl[i].e0));
         chk($sformatf("tbl%0d rd_data1", i), 64'(a_rd_data[2*XLEN-1:XLEN]), 64'(tbl[i].e1));
         chk($sformatf("tbl%0d rd_busy", i), 64'(a_rd_busy), 64'(tbl[i].eb));
         chk($sformatf("tbl%0d busy_vec", i), 64'(a_busy_vec), 64'(tbl[i].ebv));
         check_models();
         tick();
      end
      idle_a();

      // Non-bypass build: old value this cycle, new value next cycle
      b_wr_en = 1'b1; b_wr_addr = 5'd3; b_wr_data = 32'h11111111;
      step();
      b_wr_data = 32'hA5A5A5A5; b_rd_addr = {5'd3, 5'd3};
      @(negedge clk);
      chk("B nobypass old p0", 64'(b_rd_data[XLEN-1:0]), 64'h11111111);
      chk("B nobypass old p1", 64'(b_rd_data[2*XLEN-1:XLEN]), 64'h11111111);
      check_models();
      tick();
      idle_b();
      @(negedge clk);
      chk("B nobypass new", 64'(b_rd_data[XLEN-1:0]), 64'hA5A5A5A5);
      check_models();
      tick();

      // Non-bypass build: retiring write does not mask busy in its own cycle
      b_alloc_en = 1'b1; b_alloc_addr = 5'd9; b_rd_addr = {5'd0, 5'd9};
      step();
      idle_b();
      b_wr_en = 1'b1; b_wr_addr = 5'd9; b_wr_data = 32'h77;
      @(negedge clk);
      chk("B busy during retire", 64'(b_rd_busy[0]), 64'd1);
      chk("B data during retire", 64'(b_rd_data[XLEN-1:0]), 64'd0);
      check_models();
      tick();
      idle_b();
      @(negedge clk);
      chk("B busy after retire", 64'(b_rd_busy[0]), 64'd0);
      chk("B data after retire", 64'(b_rd_data[XLEN-1:0]), 64'h77);
      check_models();
      tick();

      // Randomized traffic on both builds against the model
      for (int c = 0; c < 600; c++) begin
         a_wr_en      = 2'($urandom_range(0, 3));
         a_wr_addr    = {rand_addr(), rand_addr()};
         a_wr_data    = {32'($urandom), 32'($urandom)};
         a_alloc_en   = ($urandom_range(0, 2) == 0);
         a_alloc_addr = rand_addr();
         a_flush      = ($urandom_range(0, 15) == 0);
         a_rd_addr    = {rand_addr(), rand_addr()};
         b_wr_en      = 1'($urandom_range(0, 1));
         b_wr_addr    = rand_addr();
         b_wr_data    = 32'($urandom);
         b_alloc_en   = ($urandom_range(0, 2) == 0);
         b_alloc_addr = rand_addr();
         b_flush      = ($urandom_range(0, 15) == 0);
         b_rd_addr    = {rand_addr(), rand_addr()};
         step();
      end

      // Mid-run async reset
      idle_a(); idle_b();
      a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEADBEEF};
      a_alloc_en = 1'b1; a_alloc_addr = 5'd12;
      b_alloc_en = 1'b1; b_alloc_addr = 5'd12;
      step();
      idle_a(); idle_b();
      a_rd_addr = {5'd12, 5'd5};
      @(negedge clk);
      chk("pre-reset x5", 64'(a_rd_data[XLEN-1:0]), 64'hDEADBEEF);
      chk("pre-reset busy x12", 64'(a_rd_busy[1]), 64'd1);
      check_models();
      #2;
      rst_n = 1'b0;
      #1;
      clear_models();
      chk("in-reset x5", 64'(a_rd_data[XLEN-1:0]), 64'd0);
      chk("in-reset A busy_vec", 64'(a_busy_vec), 64'd0);
      chk("in-reset B busy_vec", 64'(b_busy_vec), 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      @(negedge clk);
      chk("post-reset x5", 64'(a_rd_data[XLEN-1:0]), 64'd0);
      chk("post-reset A busy_vec", 64'(a_busy_vec), 64'd0);
      check_models();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the ID stage; successor to the single-read-pair, single-write file.
- Provides NUM_RD combinational read ports, NUM_WR write ports, optional write-to-read bypass, async clear, and a per-register busy scoreboard.
- The scoreboard tracks in-flight producers so the hazard unit can stall on long-latency results.

Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers (power of 2)
- AW, $clog2(NREG), register index width
- NUM_RD, 2, read ports
- NUM_WR, 1, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- rd_addr  in  NUM_RD*AW  packed read indices, port i at [i*AW +: AW]
- rd_data  out  NUM_RD*XLEN  packed read data
- rd_busy  out  NUM_RD  read register has an outstanding producer
- wr_en  in  NUM_WR  write enables
- wr_addr  in  NUM_WR*AW  write indices
- wr_data  in  NUM_WR*XLEN  write data
- alloc_en  in  1  mark register busy (issue of a long-latency op)
- alloc_addr  in  AW  register to mark busy
- flush  in  1  clear all busy bits (pipeline flush)
- busy_vec  out  NREG  full scoreboard, for debug and hazard unit

Behaviour:
- Reset: async on rst_n low. All NREG entries = 0, all busy bits = 0. Outputs are combinational, so they read 0 and not-busy during reset. Deassertion is used synchronously.
- Register 0: hardwired zero. Writes to index 0 are discarded, alloc to 0 is ignored, busy[0] is always 0, and reads of 0 return 0 even when bypassed.
- Write: on posedge clk, each wr_en[j] with wr_addr[j] != 0 updates the entry. If two write ports hit the same index in one cycle, the higher port index wins.
- Read, combinational:
  - Index 0 returns 0.
  - Otherwise, if BYPASS and any wr_en[j] matches the index, return that port's wr_data, with the highest matching j winning.
  - Otherwise return the stored entry.
  - With BYPASS = 0, reads return the old value until the next cycle.
- Scoreboard, updated on posedge clk, with priority high to low:
  - flush: all busy bits = 0. A flush coincident with alloc also clears the allocated bit.
  - alloc_en with alloc_addr != 0 sets busy[alloc_addr]. If a write to the same index occurs in the same cycle, busy ends set: the new producer supersedes the retiring one.
  - wr_en[j] with wr_addr[j] != 0 clears busy[wr_addr[j]].
- rd_busy[i] = busy[rd_addr[i]] & ~(BYPASS & same-cycle write to rd_addr[i]) & (rd_addr[i] != 0). A result arriving this cycle therefore does not stall its consumer when bypass is on.
- Writes never stall; there is no full or empty condition. A write to a non-busy register is legal and simply updates it.
- Latency:
  - Write to storage: 1 cycle.
  - Bypass read: 0 cycles.
  - Alloc to busy visible: 1 cycle.
- No X propagation: indices ≥ NREG cannot occur because AW = log2(NREG).

Decomposition:
- Shared package rv_pkg holds XLEN, NREG, the register-index typedef, and the ZERO_REG constant.
- One sub-module, regfile_scoreboard, owns the busy vector: the flush/alloc/clear priority logic and busy_vec.
- The top instantiates the scoreboard alongside the storage array and the generate-based read and bypass muxes.

Test Plan:
- Reset: hold rst_n low mid-run after writing x5 = 0xDEADBEEF, then release. Read x5 -> 0; busy_vec -> all 0.
- x0: write 0x1234 to index 0 with wr_en = 1 and alloc x0. Read x0 -> 0 and rd_busy = 0, both in the same cycle and the next.
- Bypass: BYPASS = 1, write x3 = 0xA5A5A5A5 while reading x3 on both ports -> same-cycle rd_data = 0xA5A5A5A5. Repeat with BYPASS = 0 -> old value, new value one cycle later.
- Dual-write collision: NUM_WR = 2, port0 writes x7 = 1 and port1 writes x7 = 2 in one cycle. Next-cycle read x7 -> 2; same-cycle bypass -> 2.
- Scoreboard:
  - alloc x9 -> next cycle rd_busy = 1 for x9.
  - Write x9 = 0x55 -> bypass cycle rd_busy = 0, data 0x55, busy cleared next cycle.
  - Alloc x9 and write x9 together -> busy stays 1.
- Flush: alloc x4, x6, x8 on consecutive cycles, then flush with a simultaneous alloc of x10 -> busy_vec = 0 the next cycle.
